// File: rtl/gbx_initiator.sv
// Single-outstanding GBX bus initiator: turns a command / write-stream / read-stream
// interface into GBX request, write-data and response handshakes with error/timeout status.
module gbx_initiator #(
    parameter logic [15:0] ID      = 16'h0001,
    parameter logic [15:0] USER    = 16'h0000,
    parameter int          TIMEOUT = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [31:0] cmd_addr,
    input  logic [3:0]  cmd_len,
    input  logic [1:0]  cmd_size,
    input  logic        wr_valid,
    output logic        wr_ready,
    input  logic [31:0] wr_data,
    output logic        rd_valid,
    input  logic        rd_ready,
    output logic [31:0] rd_data,
    output logic        rd_last,
    output logic        done,
    output logic [1:0]  done_err,
    output logic        greqvalid,
    output logic        greqwrite,
    output logic [31:0] greqaddr,
    output logic [3:0]  greqlen,
    output logic [15:0] greqid,
    output logic [15:0] grequser,
    output logic [1:0]  greqsize,
    output logic        greqdvalid,
    output logic        greqdlast,
    output logic [31:0] greqdata,
    input  logic        greqready,
    input  logic        grspvalid,
    input  logic        grspwerr,
    input  logic        grsprerr,
    input  logic        grsplast,
    input  logic [31:0] grspdata,
    input  logic [15:0] grspid,
    input  logic [15:0] grspuser,
    output logic        grspready
);
    localparam logic [2:0]  S_IDLE  = 3'd0;
    localparam logic [2:0]  S_ADDR  = 3'd1;
    localparam logic [2:0]  S_WDATA = 3'd2;
    localparam logic [2:0]  S_RESP  = 3'd3;
    localparam logic [2:0]  S_DONE  = 3'd4;
    localparam bit          TMO_EN  = (TIMEOUT > 0);
    localparam logic [31:0] TMO_LAST = (TIMEOUT > 0) ? 32'(TIMEOUT - 1) : 32'd0;

    logic [2:0]  state_r, state_s;
    logic        write_r, write_s;
    logic [31:0] addr_r, addr_s;
    logic [3:0]  len_r, len_s;
    logic [1:0]  size_r, size_s;
    logic [3:0]  cnt_r, cnt_s;
    logic [31:0] tmo_r, tmo_s;
    logic [1:0]  err_r, err_s;
    logic        done_r, done_s;
    logic [1:0]  done_err_r, done_err_s;
    logic        drain_r, drain_s;
    logic        addr_hs_s, wbeat_s, rbeat_s, wrsp_s, hs_s, waiting_s, tmo_hit_s, illegal_s;
    logic [1:0]  beat_err_s;
    logic        rd_state_s;
    logic        unused_s;

    assign unused_s = ^grspuser;

    // Handshake decode, timeout detection and per-beat error classification
    always_comb begin
        addr_hs_s  = (state_r == S_ADDR) && greqready;
        wbeat_s    = (state_r == S_WDATA) && wr_valid && greqready;
        rbeat_s    = (state_r == S_RESP) && !write_r && grspvalid && rd_ready;
        wrsp_s     = (state_r == S_RESP) && write_r && grspvalid;
        hs_s       = addr_hs_s || wbeat_s || rbeat_s || wrsp_s;
        waiting_s  = (state_r == S_ADDR) || (state_r == S_WDATA) || (state_r == S_RESP);
        tmo_hit_s  = TMO_EN && waiting_s && !hs_s && (tmo_r == TMO_LAST);
        illegal_s  = (state_r == S_IDLE) && cmd_valid && (cmd_size == 2'd3);
        beat_err_s = 2'd0;
        if (rbeat_s) begin
            // A read must end exactly on its len+1-th beat; both early and missing last count
            if (grsprerr) beat_err_s = 2'd1;
            else if (grspid != ID) beat_err_s = 2'd2;
            else if (grsplast != (cnt_r == 4'd0)) beat_err_s = 2'd1;
            else beat_err_s = 2'd0;
        end else if (wrsp_s) begin
            if (grspwerr) beat_err_s = 2'd1;
            else if (grspid != ID) beat_err_s = 2'd2;
            else if (!grsplast) beat_err_s = 2'd1;
            else beat_err_s = 2'd0;
        end else begin
            beat_err_s = 2'd0;
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_s = state_r;
        write_s = write_r;
        addr_s  = addr_r;
        len_s   = len_r;
        size_s  = size_r;
        cnt_s   = cnt_r;
        drain_s = drain_r;
        tmo_s   = (waiting_s && !hs_s) ? tmo_r + 32'd1 : 32'd0;
        err_s   = ((err_r == 2'd0) && (beat_err_s != 2'd0)) ? beat_err_s : err_r;
        case (state_r)
            S_IDLE: begin
                if (cmd_valid) begin
                    drain_s = 1'b0;
                    if (cmd_size != 2'd3) begin
                        write_s = cmd_write;
                        addr_s  = cmd_addr;
                        len_s   = cmd_len;
                        size_s  = cmd_size;
                        cnt_s   = cmd_len;
                        err_s   = 2'd0;
                        state_s = S_ADDR;
                    end else begin
                        state_s = S_IDLE;
                    end
                end else if (drain_r && grspvalid && grsplast) begin
                    drain_s = 1'b0;
                end else begin
                    drain_s = drain_r;
                end
            end
            S_ADDR: begin
                if (addr_hs_s) state_s = write_r ? S_WDATA : S_RESP;
                else state_s = S_ADDR;
            end
            S_WDATA: begin
                if (wbeat_s && (cnt_r == 4'd0)) state_s = S_RESP;
                else if (wbeat_s) cnt_s = cnt_r - 4'd1;
                else state_s = S_WDATA;
            end
            S_RESP: begin
                if (rbeat_s) begin
                    cnt_s   = (cnt_r == 4'd0) ? 4'd0 : cnt_r - 4'd1;
                    state_s = grsplast ? S_DONE : S_RESP;
                end else if (wrsp_s) begin
                    state_s = S_DONE;
                end else begin
                    state_s = S_RESP;
                end
            end
            S_DONE:  state_s = S_IDLE;
            default: state_s = S_IDLE;
        endcase
        // Timeout overrides whatever the state was doing; late responses are drained in IDLE
        state_s    = tmo_hit_s ? S_DONE : state_s;
        err_s      = tmo_hit_s ? 2'd3 : err_s;
        drain_s    = tmo_hit_s ? 1'b1 : drain_s;
        done_s     = illegal_s || (state_s == S_DONE);
        done_err_s = illegal_s ? 2'd1 : ((state_s == S_DONE) ? err_s : 2'd0);
    end

    // State and status registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r    <= S_IDLE;
            write_r    <= 1'b0;
            addr_r     <= 32'd0;
            len_r      <= 4'd0;
            size_r     <= 2'd0;
            cnt_r      <= 4'd0;
            tmo_r      <= 32'd0;
            err_r      <= 2'd0;
            done_r     <= 1'b0;
            done_err_r <= 2'd0;
            drain_r    <= 1'b0;
        end else begin
            state_r    <= state_s;
            write_r    <= write_s;
            addr_r     <= addr_s;
            len_r      <= len_s;
            size_r     <= size_s;
            cnt_r      <= cnt_s;
            tmo_r      <= tmo_s;
            err_r      <= err_s;
            done_r     <= done_s;
            done_err_r <= done_err_s;
            drain_r    <= drain_s;
        end
    end

    assign rd_state_s = (state_r == S_RESP) && !write_r;
    assign cmd_ready  = (state_r == S_IDLE);
    assign greqvalid  = (state_r == S_ADDR);
    assign greqwrite  = write_r;
    assign greqaddr   = addr_r;
    assign greqlen    = len_r;
    assign greqsize   = size_r;
    assign greqid     = ID;
    assign grequser   = USER;
    assign wr_ready   = (state_r == S_WDATA) && greqready;
    assign greqdvalid = (state_r == S_WDATA) && wr_valid;
    assign greqdlast  = (state_r == S_WDATA) && wr_valid && (cnt_r == 4'd0);
    assign greqdata   = (state_r == S_WDATA) ? wr_data : 32'd0;
    assign rd_valid   = rd_state_s && grspvalid;
    assign rd_data    = rd_state_s ? grspdata : 32'd0;
    assign rd_last    = rd_state_s && grsplast;
    assign grspready  = (rd_state_s && rd_ready) || ((state_r == S_RESP) && write_r) ||
                        ((state_r == S_IDLE) && drain_r);
    assign done       = done_r;
    assign done_err   = done_err_r;
endmodule

// File: tb/tb_gbx_initiator.sv
// Randomized bench for gbx_initiator: a bench-side GBX responder plus a transaction-level
// expectation model (expected beats, status code, timeout gap) checks every cycle.
module tb_gbx_initiator;
    localparam int TMO = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_addr;
    logic [3:0]  cmd_len;
    logic [1:0]  cmd_size;
    logic        wr_valid, wr_ready;
    logic [31:0] wr_data;
    logic        rd_valid, rd_ready, rd_last;
    logic [31:0] rd_data;
    logic        done;
    logic [1:0]  done_err;
    logic        greqvalid, greqwrite, greqdvalid, greqdlast, greqready;
    logic [31:0] greqaddr, greqdata;
    logic [3:0]  greqlen;
    logic [15:0] greqid, grequser;
    logic [1:0]  greqsize;
    logic        grspvalid, grspwerr, grsprerr, grsplast, grspready;
    logic [31:0] grspdata;
    logic [15:0] grspid, grspuser;

    int checks = 0;
    int errors = 0;

    gbx_initiator #(.ID(16'h0001), .USER(16'h0000), .TIMEOUT(TMO)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_size(cmd_size),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_last(rd_last),
        .done(done), .done_err(done_err),
        .greqvalid(greqvalid), .greqwrite(greqwrite), .greqaddr(greqaddr), .greqlen(greqlen),
        .greqid(greqid), .grequser(grequser), .greqsize(greqsize),
        .greqdvalid(greqdvalid), .greqdlast(greqdlast), .greqdata(greqdata), .greqready(greqready),
        .grspvalid(grspvalid), .grspwerr(grspwerr), .grsprerr(grsprerr), .grsplast(grsplast),
        .grspdata(grspdata), .grspid(grspid), .grspuser(grspuser), .grspready(grspready)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive_idle();
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 32'd0; cmd_len = 4'd0; cmd_size = 2'd0;
        wr_valid = 1'b0; wr_data = 32'd0; rd_ready = 1'b0; greqready = 1'b0;
        grspvalid = 1'b0; grspwerr = 1'b0; grsprerr = 1'b0; grsplast = 1'b0;
        grspdata = 32'd0; grspid = 16'h0001; grspuser = 16'h0000;
    endtask

    // mode: 0 ok, 1 bus error, 2 ID mismatch, 3 early last (read), 4 silent responder
    task automatic run_txn(input bit wr, input logic [31:0] a, input logic [3:0] ln,
                           input logic [1:0] sz, input int mode, input bit nowait,
                           input logic [31:0] base, input int stall, input int rst_at);
        logic [31:0] dat [16];
        logic [1:0]  exp_err;
        int nrsp, bad, phase, wb, rb, gap, vcyc, astall;
        bit hs, fin, aborted, frc;
        for (int i = 0; i < 16; i++) dat[i] = (base != 32'd0) ? base + 32'(i) : $urandom();
        nrsp    = (mode == 3) ? int'(ln) : int'(ln) + 1;
        bad     = wr ? 0 : $urandom_range(0, nrsp - 1);
        exp_err = (mode == 0) ? 2'd0 : (mode == 2) ? 2'd2 : (mode == 4) ? 2'd3 : 2'd1;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_len = ln; cmd_size = sz;
        #1 check_val("cmd_ready_idle", cmd_ready, 1);
        @(negedge clk);
        cmd_valid = 1'b0;
        phase = 0; wb = 0; rb = 0; gap = 0; vcyc = 0; astall = stall; fin = 0; aborted = 0;
        for (int cyc = 0; cyc < 300 && !fin && !aborted; cyc++) begin
            if (cyc != 0) @(negedge clk);
            frc       = (gap >= 6);
            greqready = (nowait || frc) ? 1'b1 : ($urandom_range(0, 3) != 0);
            if (phase == 0 && astall > 0) begin greqready = 1'b0; astall--; end
            wr_valid  = (nowait || frc) ? 1'b1 : ($urandom_range(0, 3) != 0);
            wr_data   = dat[wb & 15];
            rd_ready  = (nowait || frc) ? 1'b1 : ($urandom_range(0, 1) != 0);
            grspvalid = 1'b0; grsplast = 1'b0; grsprerr = 1'b0; grspwerr = 1'b0;
            grspid = 16'h0001; grspdata = 32'd0;
            if (phase == 2 && mode != 4 && (nowait || frc || $urandom_range(0, 2) != 0)) begin
                grspvalid = 1'b1;
                grspdata  = wr ? 32'd0 : dat[rb & 15];
                grsplast  = wr ? 1'b1 : (rb == nrsp - 1);
                if (rb == bad && mode == 1) begin grspwerr = wr; grsprerr = !wr; end
                if (rb == bad && mode == 2) grspid = 16'h0002;
            end
            if (phase == 1 && wb == rst_at) begin
                wr_valid = 1'b1; greqready = 1'b1;
                #1 reset = 1'b1;
                #1;
                check_val("rst_greqdvalid", greqdvalid, 0);
                check_val("rst_wr_ready", wr_ready, 0);
                check_val("rst_greqaddr", greqaddr, 0);
                check_val("rst_cmd_ready", cmd_ready, 1);
                check_val("rst_done", done, 0);
                @(negedge clk);
                drive_idle();
                reset = 1'b0;
                for (int k = 0; k < 3; k++) begin
                    #1 check_val("post_rst_done", done, 0);
                    check_val("post_rst_greqvalid", greqvalid, 0);
                    @(negedge clk);
                end
                aborted = 1;
            end else begin
                #1;
                hs = 0;
                if (done) begin
                    if (mode == 4) check_val("tmo_gap", gap, TMO);
                    else check_val("done_phase", phase, 3);
                    check_val("done_err", done_err, exp_err);
                    check_val("done_cmd_ready", cmd_ready, 0);
                    fin = 1;
                end else begin
                    check_val("done_expected", done, phase == 3);
                    check_val("greqvalid", greqvalid, phase == 0);
                    check_val("wr_ready", wr_ready, (phase == 1) && greqready);
                    check_val("greqdvalid", greqdvalid, (phase == 1) && wr_valid);
                    check_val("rd_valid", rd_valid, (phase == 2) && !wr && grspvalid);
                    check_val("grspready", grspready, (phase == 2) && (wr || rd_ready));
                    case (phase)
                        0: if (greqvalid) begin
                            vcyc++;
                            check_val("greqaddr", greqaddr, a);
                            check_val("greqlen", greqlen, ln);
                            check_val("greqsize", greqsize, sz);
                            check_val("greqwrite", greqwrite, wr);
                            check_val("greqid", greqid, 16'h0001);
                            check_val("grequser", grequser, 16'h0000);
                            if (greqready) begin hs = 1; phase = wr ? 1 : 2; end
                        end
                        1: if (greqdvalid && greqready) begin
                            check_val("greqdata", greqdata, dat[wb & 15]);
                            check_val("greqdlast", greqdlast, wb == int'(ln));
                            hs = 1; wb++;
                            if (wb > int'(ln)) phase = 2;
                        end
                        2: if (grspvalid && grspready) begin
                            hs = 1;
                            if (!wr) begin
                                check_val("rd_data", rd_data, dat[rb & 15]);
                                check_val("rd_last", rd_last, rb == nrsp - 1);
                            end
                            rb++;
                            if (grsplast) phase = 3;
                        end
                        default: ;
                    endcase
                    gap = hs ? 0 : gap + 1;
                end
            end
        end
        if (!aborted) begin
            check_val("txn_done", fin, 1);
            if (nowait) check_val("one_greqvalid_cycle", vcyc, 1);
            if (stall > 0) check_val("addr_stall_held", vcyc > stall, 1);
            @(negedge clk);
            drive_idle();
            if (mode == 4) begin grspvalid = 1'b1; grsplast = 1'b1; grspdata = 32'hDEAD; end
            #1;
            check_val("done_one_cycle", done, 0);
            check_val("late_grspready", grspready, mode == 4);
            check_val("late_rd_valid", rd_valid, 0);
            @(negedge clk);
            drive_idle();
            #1 check_val("drain_cleared", grspready, 0);
        end
    endtask

    initial begin
        int m;
        bit w;
        logic [3:0] l;
        drive_idle();
        reset = 1'b1;
        #1;
        check_val("reset_cmd_ready", cmd_ready, 1);
        check_val("reset_greqvalid", greqvalid, 0);
        check_val("reset_greqid", greqid, 16'h0001);
        check_val("reset_grequser", grequser, 16'h0000);
        check_val("reset_done", done, 0);
        check_val("reset_grspready", grspready, 0);
        check_val("reset_wr_ready", wr_ready, 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        run_txn(1'b1, 32'h0000_6000, 4'd0, 2'd2, 0, 1'b1, 32'h1, 0, -1);
        run_txn(1'b0, 32'h0000_0100, 4'd3, 2'd2, 0, 1'b0, 32'hA0, 0, -1);
        run_txn(1'b0, 32'h0000_0200, 4'd1, 2'd1, 0, 1'b0, 32'd0, 5, -1);
        run_txn(1'b0, 32'h0000_0300, 4'd2, 2'd2, 2, 1'b0, 32'd0, 0, -1);
        run_txn(1'b1, 32'h0000_0400, 4'd1, 2'd2, 4, 1'b0, 32'd0, 0, -1);
        run_txn(1'b1, 32'h0000_0440, 4'd0, 2'd2, 0, 1'b0, 32'd0, 0, -1);

        // illegal size is reported without touching the bus
        @(negedge clk);
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_size = 2'd3; cmd_addr = 32'h700;
        #1 check_val("illegal_cmd_ready", cmd_ready, 1);
        @(negedge clk);
        cmd_valid = 1'b0;
        #1;
        check_val("illegal_done", done, 1);
        check_val("illegal_done_err", done_err, 1);
        check_val("illegal_stays_idle", cmd_ready, 1);
        check_val("illegal_no_greqvalid", greqvalid, 0);
        @(negedge clk);
        #1 check_val("illegal_done_pulse", done, 0);

        run_txn(1'b1, 32'h0000_0500, 4'd7, 2'd2, 0, 1'b0, 32'd0, 0, 2);
        run_txn(1'b1, 32'h0000_0540, 4'd3, 2'd2, 0, 1'b0, 32'd0, 0, -1);

        for (int t = 0; t < 30; t++) begin
            w = 1'($urandom_range(0, 1));
            l = 4'($urandom_range(0, 15));
            m = $urandom_range(0, 4);
            if (m == 3 && (w || l == 4'd0)) m = 0;
            run_txn(w, $urandom(), l, 2'($urandom_range(0, 2)), m, 1'b0, 32'd0, 0, -1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
